// File: rtl/dmem_access_sequencer_pkg.sv
// Shared types for the data-memory access sequencer: address/data words and FSM encoding.
package dmem_access_sequencer_pkg;

    localparam int WIDTH_SIZE_DMEM = 10;
    localparam int WIDTH_ADDR      = WIDTH_SIZE_DMEM;
    localparam int WIDTH_DATA      = 32;

    typedef logic [WIDTH_ADDR-1:0] address_t;
    typedef logic [WIDTH_DATA-1:0] dmem_t;

    typedef enum logic [1:0] {
        FSM_DSEQ_IDLE = 2'd0,
        FSM_DSEQ_RUN  = 2'd1,
        FSM_DSEQ_DONE = 2'd2
    } fsm_dmem_seq_t;

endpackage

// File: rtl/dmem_access_sequencer_if.sv
// Bundle of requester descriptors, requester responses and the single memory port.
interface dmem_access_sequencer_if #(
    parameter int NUM_REQ = 2
);
    import dmem_access_sequencer_pkg::*;

    // Handshakes: I_Req[i] is a level request accepted by the one-cycle O_Grant[i]
    // pulse; the memory access transfers on any cycle where O_Mem_Req and I_Mem_Ready
    // are both high, and all O_Mem_* stay stable while I_Mem_Ready is low.
    logic [NUM_REQ-1:0]            I_Req;
    logic [NUM_REQ*WIDTH_ADDR-1:0] I_Base;
    logic [NUM_REQ*WIDTH_ADDR-1:0] I_Stride;
    logic [NUM_REQ*WIDTH_ADDR-1:0] I_Len;
    logic [NUM_REQ-1:0]            I_We;
    logic [NUM_REQ*WIDTH_DATA-1:0] I_WData;

    logic [NUM_REQ-1:0]            O_Grant;
    logic [NUM_REQ-1:0]            O_WAck;
    logic [NUM_REQ-1:0]            O_RValid;
    dmem_t                         O_RData;
    logic [NUM_REQ-1:0]            O_Done;

    logic                          O_Mem_Req;
    logic                          O_Mem_We;
    address_t                      O_Mem_Addr;
    dmem_t                         O_Mem_WData;
    logic                          I_Mem_Ready;
    dmem_t                         I_Mem_RData;

    fsm_dmem_seq_t                 O_Dbg_State;

    modport master (
        output I_Req, I_Base, I_Stride, I_Len, I_We, I_WData,
        output I_Mem_Ready, I_Mem_RData,
        input  O_Grant, O_WAck, O_RValid, O_RData, O_Done,
        input  O_Mem_Req, O_Mem_We, O_Mem_Addr, O_Mem_WData,
        input  O_Dbg_State
    );

    modport slave (
        input  I_Req, I_Base, I_Stride, I_Len, I_We, I_WData,
        input  I_Mem_Ready, I_Mem_RData,
        output O_Grant, O_WAck, O_RValid, O_RData, O_Done,
        output O_Mem_Req, O_Mem_We, O_Mem_Addr, O_Mem_WData,
        output O_Dbg_State
    );

endinterface

// File: rtl/dmem_access_sequencer_rr_arbiter.sv
// Combinational round-robin select: first set request at or after ptr, wrapping.
module dmem_access_sequencer_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [PTR_W:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One extra bit so ptr+i can be folded back below NUM_REQ.
            cand = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_vld && req[cand[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_access_sequencer.sv
// Shares one data-memory port between NUM_REQ strided-burst requesters, one burst at a time.
module dmem_access_sequencer
    import dmem_access_sequencer_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input logic                   clock,
    input logic                   reset,
    dmem_access_sequencer_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    fsm_dmem_seq_t      state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [PTR_W-1:0]   rd_win_q, rd_win_d;
    address_t           cur_q, cur_d;
    address_t           stride_q, stride_d;
    address_t           len_q, len_d;
    address_t           cnt_q, cnt_d;
    logic               we_q, we_d;
    logic               rd_pend_q, rd_pend_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_vld;

    address_t           base_sel;
    address_t           stride_sel;
    address_t           len_sel;
    logic               we_sel;
    dmem_t              wdata_sel;

    logic               mem_active;
    logic               mem_accept;
    logic               last_beat;
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] rd_onehot;

    dmem_access_sequencer_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (bus.I_Req),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    always_comb begin
        base_sel   = bus.I_Base[arb_idx*WIDTH_ADDR +: WIDTH_ADDR];
        stride_sel = bus.I_Stride[arb_idx*WIDTH_ADDR +: WIDTH_ADDR];
        len_sel    = bus.I_Len[arb_idx*WIDTH_ADDR +: WIDTH_ADDR];
        we_sel     = bus.I_We[arb_idx];
        // Store data follows the requester live so it can advance on each O_WAck.
        wdata_sel  = bus.I_WData[win_q*WIDTH_DATA +: WIDTH_DATA];
    end

    always_comb begin
        mem_active = (state_q == FSM_DSEQ_RUN);
        mem_accept = mem_active && bus.I_Mem_Ready;
        last_beat  = (cnt_q == len_q - address_t'(1));
        win_onehot = NUM_REQ'(1) << win_q;
        rd_onehot  = NUM_REQ'(1) << rd_win_q;
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_d     = win_q;
        cur_d     = cur_q;
        stride_d  = stride_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        rd_pend_d = mem_accept && !we_q;
        rd_win_d  = win_q;

        case (state_q)
            FSM_DSEQ_IDLE: begin
                if (arb_vld) begin
                    win_d    = arb_idx;
                    cur_d    = base_sel;
                    stride_d = stride_sel;
                    len_d    = len_sel;
                    we_d     = we_sel;
                    cnt_d    = '0;
                    state_d  = (len_sel == '0) ? FSM_DSEQ_DONE : FSM_DSEQ_RUN;
                end
            end
            FSM_DSEQ_RUN: begin
                if (bus.I_Mem_Ready) begin
                    cur_d = cur_q + stride_q;
                    cnt_d = cnt_q + address_t'(1);
                    if (last_beat) begin
                        state_d = FSM_DSEQ_DONE;
                    end
                end
            end
            FSM_DSEQ_DONE: begin
                rr_ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
                state_d  = FSM_DSEQ_IDLE;
            end
            default: begin
                state_d = FSM_DSEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= FSM_DSEQ_IDLE;
            rr_ptr_q  <= '0;
            win_q     <= '0;
            rd_win_q  <= '0;
            cur_q     <= '0;
            stride_q  <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            win_q     <= win_d;
            rd_win_q  <= rd_win_d;
            cur_q     <= cur_d;
            stride_q  <= stride_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    always_comb begin
        // Grant is combinational from IDLE; masking with reset keeps it quiet while held in reset.
        bus.O_Grant     = (state_q == FSM_DSEQ_IDLE && reset) ? arb_grant : '0;
        bus.O_Done      = (state_q == FSM_DSEQ_DONE) ? win_onehot : '0;
        bus.O_WAck      = (mem_accept && we_q) ? win_onehot : '0;
        bus.O_RValid    = rd_pend_q ? rd_onehot : '0;
        bus.O_RData     = rd_pend_q ? bus.I_Mem_RData : '0;
        bus.O_Mem_Req   = mem_active;
        bus.O_Mem_We    = mem_active && we_q;
        bus.O_Mem_Addr  = mem_active ? cur_q : '0;
        bus.O_Mem_WData = mem_active ? wdata_sel : '0;
        bus.O_Dbg_State = state_q;
    end

endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Directed bench for dmem_access_sequencer: scoreboard of expected accesses and read returns.
module tb_dmem_access_sequencer;
    import dmem_access_sequencer_pkg::*;

    localparam int NR = 2;

    logic        clock;
    logic        reset;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_mem_req = 0;
    int          n_wack1   = 0;

    logic [42:0] exp_acc_q[$];   // {we, addr, wdata}
    logic [33:0] exp_rd_q[$];    // {rvalid one-hot, rdata}
    logic [1:0]  grant_log[$];
    logic [1:0]  done_log[$];

    logic        rd_hit;
    address_t    rd_addr;

    dmem_access_sequencer_if #(.NUM_REQ(NR)) bus ();

    dmem_access_sequencer #(.NUM_REQ(NR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic dmem_t pat(input address_t a);
        return 32'hA500_0000 | {22'h0, a};
    endfunction

    function automatic logic [127:0] all_outs();
        return {44'h0, bus.O_Grant, bus.O_WAck, bus.O_RValid, bus.O_RData, bus.O_Done,
                bus.O_Mem_Req, bus.O_Mem_We, bus.O_Mem_Addr, bus.O_Mem_WData};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_desc(input int r, input address_t base, input address_t stride,
                            input address_t len, input logic we, input dmem_t wdata);
        bus.I_Base[r*WIDTH_ADDR +: WIDTH_ADDR]   = base;
        bus.I_Stride[r*WIDTH_ADDR +: WIDTH_ADDR] = stride;
        bus.I_Len[r*WIDTH_ADDR +: WIDTH_ADDR]    = len;
        bus.I_We[r]                              = we;
        bus.I_WData[r*WIDTH_DATA +: WIDTH_DATA]  = wdata;
    endtask

    task automatic push_ld(input int r, input address_t a);
        logic [1:0] oh;
        oh = 2'b01 << r;
        exp_acc_q.push_back({1'b0, a, 32'h0});
        exp_rd_q.push_back({oh, pat(a)});
    endtask

    // sel=0 waits for O_Grant, sel=1 for O_Done; returns at the negedge the pulse is seen.
    task automatic wait_sig(input string tag, input int sel, input logic [1:0] exp,
                            input int budget, output int cycles);
        logic [1:0] v;
        cycles = 0;
        v      = '0;
        forever begin
            @(negedge clock);
            cycles++;
            v = (sel == 1) ? bus.O_Done : bus.O_Grant;
            if (v != '0 || cycles >= budget) break;
            @(posedge clock);
            #1;
        end
        check_eq(tag, v, exp);
    endtask

    // Memory model: read data appears exactly one cycle after an accepted read.
    initial begin
        bus.I_Mem_RData = 32'h5A5A_5A5A;
        forever begin
            @(negedge clock);
            rd_hit  = reset && bus.O_Mem_Req && bus.I_Mem_Ready && !bus.O_Mem_We;
            rd_addr = bus.O_Mem_Addr;
            @(posedge clock);
            #1;
            bus.I_Mem_RData = rd_hit ? pat(rd_addr) : 32'h5A5A_5A5A;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                if (bus.O_Grant != '0) grant_log.push_back(bus.O_Grant);
                if (bus.O_Done != '0) done_log.push_back(bus.O_Done);
                if (bus.O_WAck[1]) n_wack1++;
                if (bus.O_Mem_Req) begin
                    n_mem_req++;
                    if (bus.I_Mem_Ready) begin
                        if (exp_acc_q.size() == 0)
                            check_eq("acc_extra", exp_acc_q.size(), 1);
                        else
                            check_eq("acc", {bus.O_Mem_We, bus.O_Mem_Addr, bus.O_Mem_WData},
                                     exp_acc_q.pop_front());
                    end
                end else begin
                    check_eq("idle_bus_zero", {bus.O_Mem_We, bus.O_Mem_Addr, bus.O_Mem_WData}, 0);
                end
                if (bus.O_RValid != '0) begin
                    if (exp_rd_q.size() == 0)
                        check_eq("rd_extra", exp_rd_q.size(), 1);
                    else
                        check_eq("rd", {bus.O_RValid, bus.O_RData}, exp_rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        int         cyc;
        int         mem_base;
        int         wack_base;
        int         done_at;
        logic       done_seen;
        logic       wack;
        dmem_t      wd;
        logic [42:0] head;
        logic [1:0] exp_oh;

        reset           = 1'b0;
        bus.I_Req       = '0;
        bus.I_Base      = '0;
        bus.I_Stride    = '0;
        bus.I_Len       = '0;
        bus.I_We        = '0;
        bus.I_WData     = '0;
        bus.I_Mem_Ready = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_outputs", all_outs(), 0);
        check_eq("rst_state", bus.O_Dbg_State, FSM_DSEQ_IDLE);
        tick();
        reset = 1'b1;

        // Single load burst from requester 0.
        set_desc(0, 10'h010, 10'h001, 10'd4, 1'b0, 32'h0);
        push_ld(0, 10'h010);
        push_ld(0, 10'h011);
        push_ld(0, 10'h012);
        push_ld(0, 10'h013);
        done_log.delete();
        mem_base  = n_mem_req;
        bus.I_Req = 2'b01;
        wait_sig("t1_grant", 0, 2'b01, 10, cyc);
        tick();
        bus.I_Req = 2'b00;
        wait_sig("t1_done", 1, 2'b01, 20, cyc);
        check_eq("t1_latency", cyc, 5);
        check_eq("t1_last_rvalid", bus.O_RValid, 2'b01);
        tick();
        check_eq("t1_done_count", done_log.size(), 1);
        check_eq("t1_mem_cycles", n_mem_req - mem_base, 4);
        check_eq("t1_acc_left", exp_acc_q.size(), 0);
        check_eq("t1_rd_left", exp_rd_q.size(), 0);

        // Store burst from requester 1 with memory ready low every other cycle.
        set_desc(1, 10'h020, 10'h002, 10'd3, 1'b1, 32'hC0DE_0000);
        exp_acc_q.push_back({1'b1, 10'h020, 32'hC0DE_0000});
        exp_acc_q.push_back({1'b1, 10'h022, 32'hC0DE_0001});
        exp_acc_q.push_back({1'b1, 10'h024, 32'hC0DE_0002});
        done_log.delete();
        wack_base = n_wack1;
        bus.I_Req = 2'b10;
        wait_sig("bp_grant", 0, 2'b10, 10, cyc);
        tick();
        bus.I_Req = 2'b00;
        wd        = 32'hC0DE_0000;
        done_seen = 1'b0;
        done_at   = -1;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            bus.I_Mem_Ready = (c % 2) == 1;
            @(negedge clock);
            if (bus.O_Mem_Req && !bus.I_Mem_Ready && exp_acc_q.size() > 0) begin
                head = exp_acc_q[0];
                check_eq("bp_hold", {bus.O_Mem_Addr, bus.O_Mem_WData}, {head[41:32], head[31:0]});
            end
            if (bus.O_Done != '0) begin
                check_eq("bp_done", bus.O_Done, 2'b10);
                done_seen = 1'b1;
                done_at   = c;
            end
            wack = bus.O_WAck[1];
            tick();
            if (wack) begin
                wd = wd + 32'h1;
                bus.I_WData[WIDTH_DATA +: WIDTH_DATA] = wd;
            end
        end
        bus.I_Mem_Ready = 1'b1;
        check_eq("bp_done_seen", done_seen, 1'b1);
        check_eq("bp_done_cycle", done_at, 6);
        check_eq("bp_wack_count", n_wack1 - wack_base, 3);
        check_eq("bp_done_count", done_log.size(), 1);
        check_eq("bp_acc_left", exp_acc_q.size(), 0);

        // Contention: both requesters held; round-robin from requester 0.
        set_desc(0, 10'h100, 10'h001, 10'd2, 1'b0, 32'h0);
        set_desc(1, 10'h200, 10'h002, 10'd2, 1'b0, 32'h0);
        push_ld(0, 10'h100);
        push_ld(0, 10'h101);
        push_ld(1, 10'h200);
        push_ld(1, 10'h202);
        push_ld(0, 10'h100);
        push_ld(0, 10'h101);
        grant_log.delete();
        done_log.delete();
        bus.I_Req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            exp_oh = (k == 1) ? 2'b10 : 2'b01;
            wait_sig("cont_grant", 0, exp_oh, 10, cyc);
            tick();
            if (k == 2) bus.I_Req = 2'b00;
            wait_sig("cont_done", 1, exp_oh, 20, cyc);
            check_eq("cont_latency", cyc, 3);
            tick();
        end
        check_eq("cont_grant_count", grant_log.size(), 3);
        check_eq("cont_done_count", done_log.size(), 3);
        if (done_log.size() == 3)
            check_eq("cont_done_order", {done_log[0], done_log[1], done_log[2]}, 6'b01_10_01);
        check_eq("cont_rd_left", exp_rd_q.size(), 0);

        // Address wrap through the top of memory, requester 1.
        set_desc(1, 10'h3FE, 10'h003, 10'd3, 1'b0, 32'h0);
        push_ld(1, 10'h3FE);
        push_ld(1, 10'h001);
        push_ld(1, 10'h004);
        bus.I_Req = 2'b10;
        wait_sig("wrap_grant", 0, 2'b10, 10, cyc);
        tick();
        bus.I_Req = 2'b00;
        wait_sig("wrap_done", 1, 2'b10, 20, cyc);
        check_eq("wrap_latency", cyc, 4);
        check_eq("wrap_last_rvalid", bus.O_RValid, 2'b10);
        tick();
        check_eq("wrap_acc_left", exp_acc_q.size(), 0);

        // Zero-length burst: grant then done, no memory access.
        set_desc(0, 10'h123, 10'h001, 10'd0, 1'b0, 32'h0);
        mem_base  = n_mem_req;
        bus.I_Req = 2'b01;
        wait_sig("len0_grant", 0, 2'b01, 10, cyc);
        tick();
        bus.I_Req = 2'b00;
        wait_sig("len0_done", 1, 2'b01, 10, cyc);
        check_eq("len0_latency", cyc, 1);
        tick();
        check_eq("len0_no_mem", n_mem_req - mem_base, 0);

        // Reset after two of eight accesses from requester 1.
        set_desc(1, 10'h050, 10'h001, 10'd8, 1'b0, 32'h0);
        exp_acc_q.push_back({1'b0, 10'h050, 32'h0});
        exp_acc_q.push_back({1'b0, 10'h051, 32'h0});
        exp_rd_q.push_back({2'b10, pat(10'h050)});
        grant_log.delete();
        done_log.delete();
        bus.I_Req = 2'b10;
        wait_sig("rst_grant", 0, 2'b10, 10, cyc);
        tick();
        tick();
        tick();
        reset     = 1'b0;
        bus.I_Req = 2'b11;
        @(negedge clock);
        check_eq("rst_mid_outputs", all_outs(), 0);
        check_eq("rst_mid_state", bus.O_Dbg_State, FSM_DSEQ_IDLE);
        check_eq("rst_mid_acc_left", exp_acc_q.size(), 0);
        check_eq("rst_mid_rd_left", exp_rd_q.size(), 0);
        tick();
        set_desc(0, 10'h0AA, 10'h001, 10'd1, 1'b0, 32'h0);
        push_ld(0, 10'h0AA);
        reset = 1'b1;
        wait_sig("rst_regrant", 0, 2'b01, 10, cyc);
        check_eq("rst_regrant_latency", cyc, 1);
        tick();
        bus.I_Req = 2'b00;
        wait_sig("rst_post_done", 1, 2'b01, 20, cyc);
        check_eq("rst_post_latency", cyc, 2);
        check_eq("rst_post_rvalid", bus.O_RValid, 2'b01);
        tick();
        check_eq("rst_done_count", done_log.size(), 1);
        check_eq("rst_acc_left", exp_acc_q.size(), 0);
        check_eq("rst_rd_left", exp_rd_q.size(), 0);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_sequencer.md
Name: dmem_access_sequencer

Overview:
- Shares the single-ported data memory (SIZE_DATA_MEM words) between NUM_REQ requesters, e.g. the scalar unit's load and store engines.
- Each requester presents a strided-burst descriptor {req, len, stride, base}. A round-robin arbiter grants one requester at a time.
- The sequencer expands the granted descriptor into len word addresses and drives the memory port until the burst completes.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
WIDTH_ADDR, WIDTH_SIZE_DMEM (10), address/len/stride width, from pkg_tpu
WIDTH_DATA, 32, data word width, from pkg_tpu

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
I_Req  in  NUM_REQ  per-requester burst request (level)
I_Base  in  NUM_REQ*WIDTH_ADDR  start address per requester
I_Stride  in  NUM_REQ*WIDTH_ADDR  address increment per requester
I_Len  in  NUM_REQ*WIDTH_ADDR  number of words per requester
I_We  in  NUM_REQ  1 = store burst, 0 = load burst
I_WData  in  NUM_REQ*WIDTH_DATA  store data per requester
O_Grant  out  NUM_REQ  one-hot, 1-cycle pulse when a descriptor is latched
O_WAck  out  NUM_REQ  store word accepted; requester advances its I_WData
O_RValid  out  NUM_REQ  load data valid for requester
O_RData  out  WIDTH_DATA  load data (shared bus)
O_Done  out  NUM_REQ  one-hot, 1-cycle pulse at burst completion
O_Mem_Req  out  1  memory access valid
O_Mem_We  out  1  memory write enable
O_Mem_Addr  out  WIDTH_ADDR  memory address
O_Mem_WData  out  WIDTH_DATA  memory write data
I_Mem_Ready  in  1  memory accepts the access this cycle
I_Mem_RData  in  WIDTH_DATA  read data, valid exactly 1 cycle after an accepted read

Behaviour:
- Reset (asynchronous, active-low): FSM=IDLE, rr_ptr=0, counters=0, all outputs 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any I_Req is set, select the first set bit starting at rr_ptr (wrapping).
  - Latch that requester's base, stride, len and we. Pulse O_Grant[winner] and go to RUN.
  - If the latched len==0, go directly to DONE; no memory access is issued.
- RUN:
  - O_Mem_Req=1, O_Mem_Addr=cur, O_Mem_We=we_l, O_Mem_WData=I_WData[winner] (live mux).
  - On I_Mem_Ready: cur<=cur+stride_l mod 2^WIDTH_ADDR (wrap, no error) and cnt<=cnt+1. A store also pulses O_WAck[winner].
  - On the accepted access with cnt==len_l-1, go to DONE.
  - While I_Mem_Ready=0, hold address, data and counters unchanged.
- DONE:
  - Pulse O_Done[winner] and set rr_ptr<=winner+1 (mod NUM_REQ). Return to IDLE.
  - Minimum gap between bursts is therefore 2 cycles (DONE, IDLE).
- Read return:
  - rd_pend<=accepted&&!we_l. O_RValid[winner_d]=rd_pend, O_RData=I_Mem_RData.
  - The last read's O_RValid coincides with the O_Done pulse.
- Requester contract: hold I_Req and the descriptor until O_Grant. Changes after the grant are ignored. I_Req deassertion before the grant withdraws the request.
- I_Req remaining high after O_Done is treated as a new request and competes under round-robin.
- The winner is never re-arbitrated mid-burst. Other requests wait, with no starvation: at most NUM_REQ-1 bursts precede any requester.
- Memory outputs are 0 whenever O_Mem_Req=0.
- Reset mid-burst: abort immediately and return to IDLE. No O_Done is issued, and any pending O_RValid is dropped.

Decomposition:
- pkg_tpu additions:
  - typedef fsm_dmem_seq_t {FSM_DSEQ_IDLE, FSM_DSEQ_RUN, FSM_DSEQ_DONE}.
  - Reuse dmem_t/address_t for descriptors.
- One sub-module, rr_arbiter (parameter NUM_REQ): combinational one-hot select from a request vector and rr_ptr.
- Descriptor latch, address/count generator and FSM stay in the top module.

Test Plan:
- Single load: I_Req[0]=1, base=0x010, stride=1, len=4, Mem_Ready=1 -> addresses 0x010..0x013 in 4 consecutive cycles, 4 O_RValid[0], O_Done[0] once.
- Contention: I_Req=2'b11 held, both len=2, rr_ptr=0 -> grant order req0, req1, req0. O_Done alternates.
- Wrap: base=0x3FE, stride=3, len=3 -> addresses 0x3FE, 0x001, 0x004.
- Backpressure store: len=3, I_Mem_Ready low on every other cycle -> address and WData held while low. Exactly 3 O_WAck[1], then O_Done[1].
- len=0: request -> O_Grant then O_Done on the next cycle, O_Mem_Req never asserted.
- Reset mid-burst: assert reset after 2 of 8 accesses -> all outputs 0 immediately. After release, the FSM is IDLE and a new grant starts from req0.
